// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round sequencing logic.
// State encoding and legal round counts for AES-128/192/256.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        KEY0,
        ROUND,
        OUT
    } state_e;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;
    localparam int RW        = 4;

endpackage

// File: rtl/aes_round_idx.sv
// Round counter for the AES sequencer.
// Clears to zero, steps by one on advance, saturates at NR.
module aes_round_idx #(
    parameter int NR = 14,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [RW-1:0] round,
    output logic          is_last
);

    localparam logic [RW-1:0] NR_L = RW'(NR);

    logic [RW-1:0] round_d;
    logic [RW-1:0] round_q;

    always_comb begin
        round_d = round_q;
        if (clear) begin
            round_d = '0;
        end else if (advance && (round_q != NR_L)) begin
            round_d = round_q + RW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_q <= '0;
        end else begin
            round_q <= round_d;
        end
    end

    assign round   = round_q;
    assign is_last = (round_q == NR_L);

endmodule

// File: rtl/aes_round_sequencer.sv
// Control FSM stepping one AES block through the shared round datapath,
// fetching each round key over req/ack and handing off the result.
module aes_round_sequencer #(
    parameter int NR = aes_pkg::NR_AES256,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          key_req,
    output logic [RW-1:0] key_idx,
    input  logic          key_ack,
    output logic          dp_load,
    output logic          dp_round_en,
    output logic          dp_skip_mix,
    output logic [RW-1:0] round,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready
);

    import aes_pkg::*;

    if (!(NR == NR_AES128 || NR == NR_AES192 || NR == NR_AES256)) begin : g_bad_nr
        $error("aes_round_sequencer: NR must be 10, 12 or 14");
    end

    state_e state_d;
    state_e state_q;
    logic   round_clear;
    logic   round_adv;
    logic   is_last;

    aes_round_idx #(
        .NR(NR),
        .RW(RW)
    ) u_round_idx (
        .clk    (clk),
        .rst    (rst),
        .clear  (round_clear),
        .advance(round_adv),
        .round  (round),
        .is_last(is_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        key_req     = 1'b0;
        key_idx     = '0;
        dp_load     = 1'b0;
        dp_round_en = 1'b0;
        dp_skip_mix = 1'b0;
        out_valid   = 1'b0;
        round_clear = 1'b0;
        round_adv   = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = KEY0;
                end
            end
            KEY0: begin
                key_req = 1'b1;
                if (key_ack) begin
                    dp_load   = 1'b1;
                    round_adv = 1'b1;
                    state_d   = ROUND;
                end
            end
            ROUND: begin
                key_req = 1'b1;
                key_idx = round;
                if (key_ack) begin
                    dp_round_en = 1'b1;
                    dp_skip_mix = is_last;
                    // last key consumed: counter stays parked at NR
                    if (is_last) begin
                        state_d = OUT;
                    end else begin
                        round_adv = 1'b1;
                    end
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    round_clear = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench: NR=14 and NR=10 instances driven in lockstep,
// compared every cycle against a key-count reference model.
module tb_aes_round_sequencer;

    typedef struct packed {
        logic       in_ready;
        logic       key_req;
        logic [3:0] key_idx;
        logic       dp_load;
        logic       dp_round_en;
        logic       dp_skip_mix;
        logic [3:0] round;
        logic       busy;
        logic       out_valid;
    } obs_t;

    typedef struct {
        bit have;
        int k;
        int nr;
    } model_t;

    typedef struct {
        bit iv;
        bit e_load;
        bit e_ren;
        bit e_skip;
        bit e_ov;
        bit e_ir;
        int e_round;
    } vec_t;

    logic clk;
    logic rst;
    logic in_valid;
    logic key_ack;
    logic out_ready;

    logic       ir14, kr14, ld14, re14, sk14, bz14, ov14;
    logic [3:0] ki14, rd14;
    logic       ir10, kr10, ld10, re10, sk10, bz10, ov10;
    logic [3:0] ki10, rd10;

    obs_t   a14;
    obs_t   a10;
    model_t m [2];
    int     checks;
    int     errors;
    int     cyc;

    aes_round_sequencer #(.NR(14), .RW(4)) u_dut14 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir14),
        .key_req(kr14), .key_idx(ki14), .key_ack(key_ack),
        .dp_load(ld14), .dp_round_en(re14), .dp_skip_mix(sk14),
        .round(rd14), .busy(bz14), .out_valid(ov14), .out_ready(out_ready)
    );

    aes_round_sequencer #(.NR(10), .RW(4)) u_dut10 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir10),
        .key_req(kr10), .key_idx(ki10), .key_ack(key_ack),
        .dp_load(ld10), .dp_round_en(re10), .dp_skip_mix(sk10),
        .round(rd10), .busy(bz10), .out_valid(ov10), .out_ready(out_ready)
    );

    // key_idx only has meaning while a key is being requested
    always_comb begin
        a14 = '{ir14, kr14, kr14 ? ki14 : 4'd0, ld14, re14, sk14, rd14, bz14, ov14};
        a10 = '{ir10, kr10, kr10 ? ki10 : 4'd0, ld10, re10, sk10, rd10, bz10, ov10};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (!rst) begin
            assert (!(ld14 && re14)) else $error("strobe overlap nr14");
            assert (!(ld10 && re10)) else $error("strobe overlap nr10");
            assert (!sk14 || re14) else $error("skip without round nr14");
            assert (!sk10 || re10) else $error("skip without round nr10");
        end
    end

    function automatic obs_t expect_of(model_t mm, logic ka);
        obs_t e;
        logic kr;
        e = '0;
        kr = mm.have && (mm.k <= mm.nr);
        e.in_ready    = !mm.have;
        e.busy        = mm.have;
        e.key_req     = kr;
        e.key_idx     = kr ? 4'(mm.k) : 4'd0;
        e.dp_load     = kr && ka && (mm.k == 0);
        e.dp_round_en = kr && ka && (mm.k > 0);
        e.dp_skip_mix = e.dp_round_en && (mm.k == mm.nr);
        e.round       = 4'((mm.k > mm.nr) ? mm.nr : mm.k);
        e.out_valid   = mm.have && (mm.k > mm.nr);
        return e;
    endfunction

    function automatic model_t next_of(model_t mm, logic iv, logic ka, logic orr);
        model_t n;
        n = mm;
        if (!mm.have) begin
            if (iv) n.have = 1'b1;
        end else if (mm.k <= mm.nr) begin
            if (ka) n.k = mm.k + 1;
        end else if (orr) begin
            n.have = 1'b0;
            n.k    = 0;
        end
        return n;
    endfunction

    task automatic check_obs(string nm, obs_t act, obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_bits(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s idx=%0d act=%0h exp=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(bit r, bit iv, bit ka, bit orr);
        rst       = r;
        in_valid  = iv;
        key_ack   = ka;
        out_ready = orr;
        if (r) begin
            m[0].have = 1'b0; m[0].k = 0;
            m[1].have = 1'b0; m[1].k = 0;
        end
        @(negedge clk);
        check_obs("model_nr14", a14, expect_of(m[0], key_ack));
        check_obs("model_nr10", a10, expect_of(m[1], key_ack));
    endtask

    task automatic adv();
        @(posedge clk);
        if (!rst) begin
            m[0] = next_of(m[0], in_valid, key_ack, out_ready);
            m[1] = next_of(m[1], in_valid, key_ack, out_ready);
        end
        cyc++;
        #1;
    endtask

    task automatic step(bit r, bit iv, bit ka, bit orr);
        drive(r, iv, ka, orr);
        adv();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m[0].have || m[1].have) && n < 100) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            n++;
        end
        check_bits("drain_timeout", cyc, 32'(n < 100), 32'd1);
    endtask

    initial begin
        vec_t vec [18];
        obs_t rst_obs;
        int   t0, lat10, lat14, st, hold, hs, acc;

        checks = 0; errors = 0; cyc = 0;
        m[0] = '{have: 1'b0, k: 0, nr: 14};
        m[1] = '{have: 1'b0, k: 0, nr: 10};
        rst_obs = '0;
        rst_obs.in_ready = 1'b1;

        for (int c = 0; c < 18; c++) begin
            vec[c].iv      = (c == 0);
            vec[c].e_ir    = (c == 0) || (c == 17);
            vec[c].e_load  = (c == 1);
            vec[c].e_ren   = (c >= 2) && (c <= 15);
            vec[c].e_skip  = (c == 15);
            vec[c].e_ov    = (c == 16);
            vec[c].e_round = vec[c].e_ren ? c - 1 : ((c == 16) ? 14 : 0);
        end

        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_obs("reset_state_nr14", a14, rst_obs);
        check_obs("reset_state_nr10", a10, rst_obs);
        adv();

        // nominal NR=14 latency, key_ack and out_ready tied high
        for (int c = 0; c < 18; c++) begin
            drive(1'b0, vec[c].iv, 1'b1, 1'b1);
            check_bits("latency_tbl", c,
                {a14.dp_load, a14.dp_round_en, a14.dp_skip_mix,
                 a14.out_valid, a14.in_ready, a14.round},
                {vec[c].e_load, vec[c].e_ren, vec[c].e_skip,
                 vec[c].e_ov, vec[c].e_ir, 4'(vec[c].e_round)});
            adv();
        end
        drain();

        // key stall of 3 cycles while fetching round key 5
        t0 = cyc; lat10 = -1; lat14 = -1; st = 0;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 60; i++) begin
            bit ka;
            ka = !(m[1].have && m[1].k == 5 && st < 3);
            if (!ka) st++;
            drive(1'b0, 1'b0, ka, 1'b1);
            if (!ka) check_bits("stall_keyidx", i, {a10.key_req, a10.key_idx, a10.dp_round_en}, {1'b1, 4'd5, 1'b0});
            if (a10.out_valid && lat10 < 0) lat10 = cyc - t0;
            if (a14.out_valid && lat14 < 0) lat14 = cyc - t0;
            adv();
            if (!m[0].have && !m[1].have) break;
        end
        check_bits("stall_cycles", 0, st, 3);
        check_bits("stall_lat_nr10", 0, lat10, 15);
        check_bits("stall_lat_nr14", 0, lat14, 19);
        drain();

        // output back-pressure with in_valid pulses arriving meanwhile
        hold = 0;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            bit in_out;
            in_out = m[0].have && m[0].k > 14;
            drive(1'b0, 1'(i % 2), 1'b1, !(in_out && hold < 4));
            if (in_out && hold < 4) begin
                check_bits("out_hold", hold, {a14.out_valid, a14.in_ready, a14.round}, {1'b1, 1'b0, 4'd14});
                hold++;
            end
            adv();
            if (hold == 4 && !m[0].have) break;
        end
        check_bits("out_hold_cycles", 0, hold, 4);
        drain();

        // reset mid-block at round 7, then a fresh block
        step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20 && m[0].k != 7; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        check_bits("reach_round7", 0, a14.round, 7);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        check_obs("mid_reset_nr14", a14, rst_obs);
        adv();
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check_obs("post_reset_nr14", a14, rst_obs);
        adv();
        t0 = cyc; lat14 = -1;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 30 && lat14 < 0; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1);
            if (a14.out_valid) lat14 = cyc - t0;
            adv();
        end
        check_bits("post_reset_lat", 0, lat14, 16);
        drain();

        // back-to-back with in_valid held high
        hs = -1; acc = -1;
        for (int i = 0; i < 45; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1);
            if (a14.out_valid && hs < 0) hs = cyc;
            if (hs >= 0 && acc < 0 && a14.in_ready) acc = cyc;
            adv();
        end
        check_bits("b2b_gap", 0, acc - hs, 1);
        drain();

        // random traffic with occasional reset
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
